// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
//   Bus-side interface of the UART receiver: the received word, its per-word
//   error flags and the consumer's ready.
//
//   Handshake (valid/ready):
//   - The producer raises data_valid together with a stable data_out,
//     frame_error and parity_error.
//   - A word is consumed at any rising clock edge where data_valid and
//     data_ready are both high.
//   - The producer never changes data_out or the flags while data_valid is
//     high and the word is unconsumed.
//   - overrun_error is a one-cycle pulse that is independent of the handshake.
//
//   Parameter
//     DATA_BITS     : width of the received word (5..9)
//   Signals
//     data_out      : last received data word
//     data_valid    : data_out holds an unconsumed word
//     data_ready    : consumer accepts the word
//     frame_error   : stop bit of the word in data_out was sampled low
//     parity_error  : parity mismatch on the word in data_out
//     overrun_error : one-cycle pulse when a completed frame is dropped
//   Modports
//     master : receiver side (drives word and flags, reads ready)
//     slave  : consumer side
// -----------------------------------------------------------------------------
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 data_ready;
    logic                 frame_error;
    logic                 parity_error;
    logic                 overrun_error;

    modport master (
        output data_out,
        output data_valid,
        output frame_error,
        output parity_error,
        output overrun_error,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  frame_error,
        input  parity_error,
        input  overrun_error,
        output data_ready
    );
endinterface

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   UART serial receiver that sits downstream of a baud rate generator.
//
//   Operation
//   - Synchronises the rx line.
//   - Detects a start edge and enables the generator's RX tick.
//   - On each tick, samples one bit: start, LSB-first data, optional parity,
//     then stop.
//   - Presents each received word on a valid/ready interface together with
//     its per-word error flags.
//
//   Compile-time option
//     UART_RX_PARITY_EN
//       defined   : one even-parity bit follows the data bits and
//                   parity_error reports a mismatch.
//       undefined : STOP follows the last data bit and parity_error is
//                   tied to 0.
//
//   Ports
//     clock               : single clock for all logic
//     reset               : synchronous, active-low reset
//     rx                  : asynchronous serial line, idles high
//     rx_baud_rate        : one-cycle sample tick from the baud generator
//     rx_baud_rate_reg_en : enable to the baud generator
//                           (high from start edge until frame end)
//     bus                 : uart_rx_if.master
//                           (data_out / data_valid / data_ready / error flags)
//     state_dbg           : current FSM state encoding, for observation
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rx,
    input  logic             rx_baud_rate,
    output logic             rx_baud_rate_reg_en,
    uart_rx_if.master        bus,
    output logic [2:0]       state_dbg
);

    localparam int CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic                 rx_meta_q, rx_meta_d;
    logic                 rx_s_q, rx_s_d;
    logic                 rx_prev_q, rx_prev_d;
    logic                 en_q, en_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 ovr_q, ovr_d;
    logic                 start_edge;
    logic                 parity_mismatch;
    state_e               after_data;

`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;

    // Even parity: XOR over data bits plus the parity bit must be 0.
    assign parity_mismatch = (^shift_q) ^ par_q;
    assign after_data      = S_PARITY;
`else
    assign parity_mismatch = 1'b0;
    assign after_data      = S_STOP;
`endif

    // Falling edge of the synchronised line. Only acted on in IDLE, so a
    // line held low across DONE cannot start a frame until it is seen high.
    assign start_edge = rx_prev_q & ~rx_s_q;

    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        rx_prev_d = rx_s_q;
        state_d   = state_q;
        en_d      = en_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        stop_d    = stop_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = ferr_q;
        perr_d    = perr_q;
        ovr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
`endif

        // Consumption; a load in DONE below overrides this in the same cycle.
        if (valid_q && bus.data_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d = S_START;
                    en_d    = 1'b1;
                end
            end
            S_START: begin
                if (rx_baud_rate) begin
                    if (!rx_s_q) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end else begin
                        // Line was high at mid-start: treat as glitch.
                        state_d = S_IDLE;
                        en_d    = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (rx_baud_rate) begin
                    // LSB arrives first, so shift in from the top.
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        state_d = after_data;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (rx_baud_rate) begin
                    par_d   = rx_s_q;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (rx_baud_rate) begin
                    stop_d  = rx_s_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
                if (!valid_q || bus.data_ready) begin
                    data_d  = shift_q;
                    ferr_d  = ~stop_q;
                    perr_d  = parity_mismatch;
                    valid_d = 1'b1;
                end else begin
                    // Output still held: drop the new word, keep the old one.
                    ovr_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            en_q      <= 1'b0;
            cnt_q     <= '0;
            shift_q   <= '0;
            stop_q    <= 1'b1;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
            ovr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            rx_prev_q <= rx_prev_d;
            en_q      <= en_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            stop_q    <= stop_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
            ovr_q     <= ovr_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    assign rx_baud_rate_reg_en = en_q;
    assign bus.data_out        = data_q;
    assign bus.data_valid      = valid_q;
    assign bus.frame_error     = ferr_q;
    assign bus.parity_error    = perr_q;
    assign bus.overrun_error   = ovr_q;
    assign state_dbg           = state_q;

endmodule
